// File: rtl/det_box_frame_sync.sv
// Detection-box shadow register ahead of the rectangle/digit overlay: boxes arrive over
// valid/ready, are clamped to the active area, and are committed only at frame start.
module det_box_frame_sync #(
   parameter int W_COORD     = 12,
   parameter int H_ACT       = 1920,
   parameter int V_ACT       = 1080,
   parameter int HOLD_FRAMES = 8,
   parameter bit VS_POL      = 1'b1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               vsync,
   input  logic               det_valid,
   output logic               det_ready,
   input  logic [W_COORD-1:0] det_x,
   input  logic [W_COORD-1:0] det_y,
   input  logic [W_COORD-1:0] det_w,
   input  logic [W_COORD-1:0] det_h,
   input  logic [3:0]         det_digit,
   output logic [W_COORD-1:0] box_x,
   output logic [W_COORD-1:0] box_y,
   output logic [W_COORD-1:0] box_w,
   output logic [W_COORD-1:0] box_h,
   output logic [3:0]         box_digit,
   output logic               box_en,
   output logic [15:0]        ovr_cnt,
   output logic [15:0]        rej_cnt
);

   localparam int               CW       = W_COORD + 1;
   localparam logic [W_COORD:0] H_LIM    = CW'(H_ACT);
   localparam logic [W_COORD:0] V_LIM    = CW'(V_ACT);
   localparam logic [7:0]       HOLD_LIM = 8'(HOLD_FRAMES);

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FULL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t             state, state_nx;
   logic               vs_d;
   logic               fs;
   logic               accept, reject, take;
   logic [W_COORD:0]   x_ext, y_ext, w_ext, h_ext;
   logic [W_COORD:0]   room_x, room_y, w_clip, h_clip;
   logic               unused_clip_msb;
   logic [W_COORD-1:0] sh_x, sh_y, sh_w, sh_h;
   logic [3:0]         sh_digit;
   logic [7:0]         hold_cnt;

   assign fs = (vsync == VS_POL) && (vs_d != VS_POL);

   assign x_ext = {1'b0, det_x};
   assign y_ext = {1'b0, det_y};
   assign w_ext = {1'b0, det_w};
   assign h_ext = {1'b0, det_h};

   assign accept = det_valid & det_ready;
   assign reject = accept & ((x_ext >= H_LIM) | (y_ext >= V_LIM));
   assign take   = accept & ~reject;

   // Room to the right/bottom edge; only meaningful for beats that are not rejected.
   assign room_x = H_LIM - x_ext;
   assign room_y = V_LIM - y_ext;
   assign w_clip = (w_ext > room_x) ? room_x : w_ext;
   assign h_clip = (h_ext > room_y) ? room_y : h_ext;
   assign unused_clip_msb = w_clip[W_COORD] | h_clip[W_COORD];

   // NOTE: every combinational output gets a default before the case, so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         EMPTY:   if (take) state_nx = FULL;
         FULL:    if (fs)   state_nx = COMMIT;
         COMMIT:  state_nx = EMPTY;
         default: state_nx = EMPTY;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= EMPTY;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vs_d      <= ~VS_POL;
         det_ready <= 1'b0;
         sh_x      <= '0;
         sh_y      <= '0;
         sh_w      <= '0;
         sh_h      <= '0;
         sh_digit  <= '0;
         box_x     <= '0;
         box_y     <= '0;
         box_w     <= '0;
         box_h     <= '0;
         box_digit <= '0;
         box_en    <= 1'b0;
         hold_cnt  <= '0;
         ovr_cnt   <= '0;
         rej_cnt   <= '0;
      end else begin
         vs_d      <= vsync;
         det_ready <= (state_nx != COMMIT);

         if (reject && (rej_cnt != 16'hFFFF)) rej_cnt <= rej_cnt + 16'd1;

         if (take) begin
            sh_x     <= det_x;
            sh_y     <= det_y;
            sh_w     <= w_clip[W_COORD-1:0];
            sh_h     <= h_clip[W_COORD-1:0];
            sh_digit <= det_digit;
            if ((state == FULL) && (ovr_cnt != 16'hFFFF)) ovr_cnt <= ovr_cnt + 16'd1;
         end

         // Empty frames age the live box; the commit restarts the count.
         if ((state == EMPTY) && fs && (hold_cnt < HOLD_LIM)) begin
            hold_cnt <= hold_cnt + 8'd1;
            if ((hold_cnt + 8'd1) == HOLD_LIM) box_en <= 1'b0;
         end

         if (state == COMMIT) begin
            box_x     <= sh_x;
            box_y     <= sh_y;
            box_w     <= sh_w;
            box_h     <= sh_h;
            box_digit <= sh_digit;
            box_en    <= 1'b1;
            hold_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_det_box_frame_sync.sv
// Scoreboard bench for det_box_frame_sync: expected boxes are queued when beats are driven
// and popped when the frame-start commit makes them visible on box_*.
module tb_det_box_frame_sync;

   localparam int W = 12;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] w;
      logic [W-1:0] h;
      logic [3:0]   digit;
      logic         en;
   } box_t;

   logic         clk = 1'b0;
   logic         rstn;
   logic         vsync;
   logic         det_valid;
   logic         det_ready;
   logic [W-1:0] det_x, det_y, det_w, det_h;
   logic [3:0]   det_digit;
   logic [W-1:0] box_x, box_y, box_w, box_h;
   logic [3:0]   box_digit;
   logic         box_en;
   logic [15:0]  ovr_cnt, rej_cnt;

   int   n_checks = 0;
   int   n_fail   = 0;
   box_t exp_q[$];
   box_t exp_b;
   box_t last_b;

   det_box_frame_sync dut (
      .clk       (clk),
      .rstn      (rstn),
      .vsync     (vsync),
      .det_valid (det_valid),
      .det_ready (det_ready),
      .det_x     (det_x),
      .det_y     (det_y),
      .det_w     (det_w),
      .det_h     (det_h),
      .det_digit (det_digit),
      .box_x     (box_x),
      .box_y     (box_y),
      .box_w     (box_w),
      .box_h     (box_h),
      .box_digit (box_digit),
      .box_en    (box_en),
      .ovr_cnt   (ovr_cnt),
      .rej_cnt   (rej_cnt)
   );

   always #5 clk = ~clk;

   function automatic box_t get_box();
      return {box_x, box_y, box_w, box_h, box_digit, box_en};
   endfunction

   function automatic box_t mk_box(input int x, input int y, input int w, input int h,
                                   input int d, input bit en);
      box_t b;
      b.x = W'(x); b.y = W'(y); b.w = W'(w); b.h = W'(h);
      b.digit = 4'(d); b.en = en;
      return b;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_beat(input int x, input int y, input int w, input int h, input int d);
      int waited;
      waited = 0;
      while ((det_ready !== 1'b1) && (waited < 20)) begin
         tick();
         waited++;
      end
      n_checks++;
      if (det_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: det_ready=%b required 1", det_ready);
      end
      det_x = W'(x); det_y = W'(y); det_w = W'(w); det_h = W'(h); det_digit = 4'(d);
      det_valid = 1'b1;
      tick();
      det_valid = 1'b0;
   endtask

   // Single-cycle vsync pulse; returns at t+2 where a commit is visible.
   task automatic vs_pulse();
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
   endtask

   task automatic vs_rise();
      vsync = 1'b1;
      tick();
      tick();
   endtask

   task automatic vs_fall();
      vsync = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rstn = 1'b0; vsync = 1'b0; det_valid = 1'b0;
      det_x = '0; det_y = '0; det_w = '0; det_h = '0; det_digit = '0;
      repeat (3) tick();
      n_checks++;
      if ({get_box(), det_ready, ovr_cnt, rej_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: box=%h ready=%b ovr=%h rej=%h required all 0",
                  get_box(), det_ready, ovr_cnt, rej_cnt);
      end
      rstn = 1'b1;
      tick();
      n_checks++;
      if (det_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: det_ready=%b required 1", det_ready);
      end
   endtask

   task automatic test_basic();
      exp_q.push_back(mk_box(100, 50, 40, 30, 7, 1'b1));
      send_beat(100, 50, 40, 30, 7);
      repeat (3) tick();
      vsync = 1'b1;
      tick();
      n_checks++;
      if (get_box() !== '0) begin
         n_fail++;
         $display("FAIL basic_t1_box: box=%h required 0", get_box());
      end
      n_checks++;
      if (det_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_t1_ready: det_ready=%b required 0", det_ready);
      end
      tick();
      exp_b = exp_q.pop_front();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL basic_t2_box: box=%h required %h", get_box(), exp_b);
      end
      // vsync stays active: a new beat must not be committed within this frame
      exp_q.push_back(mk_box(200, 60, 10, 10, 2, 1'b1));
      send_beat(200, 60, 10, 10, 2);
      repeat (10) tick();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL vsync_held_box: box=%h required %h", get_box(), exp_b);
      end
      vs_fall();
      vs_rise();
      exp_b = exp_q.pop_front();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL second_frame_box: box=%h required %h", get_box(), exp_b);
      end
      vs_fall();
   endtask

   task automatic test_three_beats();
      exp_q.push_back(mk_box(300, 70, 20, 20, 5, 1'b1));
      send_beat(100, 10, 5, 5, 1);
      send_beat(200, 20, 6, 6, 2);
      send_beat(300, 70, 20, 20, 5);
      vs_rise();
      exp_b = exp_q.pop_front();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL three_beats_box: box=%h required %h", get_box(), exp_b);
      end
      n_checks++;
      if (ovr_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL three_beats_ovr: ovr_cnt=%0d required 2", ovr_cnt);
      end
      vs_fall();
   endtask

   task automatic test_clamp();
      exp_q.push_back(mk_box(1900, 10, 20, 20, 3, 1'b1));
      send_beat(1900, 10, 64, 20, 3);
      send_beat(5, 1080, 8, 8, 4);
      n_checks++;
      if (rej_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL reject_y: rej_cnt=%0d required 1", rej_cnt);
      end
      vs_pulse();
      exp_b = exp_q.pop_front();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL clamp_w_box: box=%h required %h", get_box(), exp_b);
      end
      send_beat(1920, 0, 4, 4, 1);
      n_checks++;
      if (rej_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL reject_x: rej_cnt=%0d required 2", rej_cnt);
      end
      exp_q.push_back(mk_box(1919, 1070, 1, 10, 9, 1'b1));
      send_beat(1919, 1070, 5, 50, 9);
      vs_pulse();
      exp_b = exp_q.pop_front();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL clamp_edge_box: box=%h required %h", get_box(), exp_b);
      end
      n_checks++;
      if (ovr_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL clamp_ovr: ovr_cnt=%0d required 2", ovr_cnt);
      end
      last_b = exp_b;
   endtask

   task automatic test_hold();
      logic en_exp;
      for (int i = 1; i <= 8; i++) begin
         vs_pulse();
         en_exp = (i < 8);
         n_checks++;
         if (box_en !== en_exp) begin
            n_fail++;
            $display("FAIL hold_en_%0d: box_en=%b required %b", i, box_en, en_exp);
         end
      end
      last_b.en = 1'b0;
      n_checks++;
      if (get_box() !== last_b) begin
         n_fail++;
         $display("FAIL hold_box_kept: box=%h required %h", get_box(), last_b);
      end
   endtask

   task automatic test_back_to_back();
      send_beat(10, 10, 10, 10, 1);
      n_checks++;
      if (det_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL fs_t0_ready: det_ready=%b required 1", det_ready);
      end
      exp_q.push_back(mk_box(20, 21, 22, 23, 2, 1'b1));
      det_x = 12'd20; det_y = 12'd21; det_w = 12'd22; det_h = 12'd23; det_digit = 4'd2;
      det_valid = 1'b1;
      vsync = 1'b1;
      tick();
      det_valid = 1'b0;
      n_checks++;
      if (det_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fs_t1_ready: det_ready=%b required 0", det_ready);
      end
      vsync = 1'b0;
      tick();
      exp_b = exp_q.pop_front();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL fs_accept_box: box=%h required %h", get_box(), exp_b);
      end
      n_checks++;
      if ((det_ready !== 1'b1) || (ovr_cnt !== 16'd3)) begin
         n_fail++;
         $display("FAIL fs_t2_state: det_ready=%b ovr_cnt=%0d required 1 and 3", det_ready, ovr_cnt);
      end
   endtask

   task automatic test_saturate();
      det_x = 12'd5; det_y = 12'd1080; det_w = 12'd1; det_h = 12'd1; det_digit = 4'd0;
      det_valid = 1'b1;
      repeat (65540) tick();
      det_valid = 1'b0;
      tick();
      n_checks++;
      if (rej_cnt !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL rej_saturate: rej_cnt=%h required ffff", rej_cnt);
      end
      n_checks++;
      if (ovr_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL sat_ovr_kept: ovr_cnt=%0d required 3", ovr_cnt);
      end
   endtask

   task automatic test_reset_commit();
      send_beat(40, 40, 40, 40, 4);
      vsync = 1'b1;
      tick();
      n_checks++;
      if (det_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rc_in_commit: det_ready=%b required 0", det_ready);
      end
      rstn = 1'b0;
      #1;
      n_checks++;
      if ({get_box(), det_ready, ovr_cnt, rej_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rc_async_clear: box=%h ready=%b ovr=%h rej=%h required all 0",
                  get_box(), det_ready, ovr_cnt, rej_cnt);
      end
      vsync = 1'b0;
      tick();
      n_checks++;
      if ({get_box(), det_ready, ovr_cnt, rej_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rc_edge_clear: box=%h ready=%b ovr=%h rej=%h required all 0",
                  get_box(), det_ready, ovr_cnt, rej_cnt);
      end
      rstn = 1'b1;
      tick();
      exp_q.push_back(mk_box(0, 0, 0, 0, 0, 1'b0));
      vs_rise();
      exp_b = exp_q.pop_front();
      n_checks++;
      if (get_box() !== exp_b) begin
         n_fail++;
         $display("FAIL rc_post_frame: box=%h required %h", get_box(), exp_b);
      end
      vs_fall();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_three_beats();
      test_clamp();
      test_hold();
      test_back_to_back();
      test_saturate();
      test_reset_commit();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

endmodule
